// File: rtl/uart_host_bfm.sv
// rtl/uart_host_bfm.sv - host-side UART terminal: 8N1 TX/RX with RX FIFO.
// Optional even parity on both directions when UART_HOST_PARITY_EN is defined.
module uart_host_bfm #(
    parameter int OVERSAMPLE    = 16,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sys_tx_i,
    output logic       sys_rx_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       rx_overrun_o,
`ifdef UART_HOST_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       frame_err_o
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF_END = CW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BREAK} state_t;

    state_t          tx_state_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_shift_q;
    logic            tx_rdy_q;
    logic            sys_rx_q;
`ifdef UART_HOST_PARITY_EN
    logic            tx_par_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_rdy_q   <= 1'b0;
            sys_rx_q   <= 1'b1;
`ifdef UART_HOST_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            case (tx_state_q)
                ST_IDLE: begin
                    tx_rdy_q <= 1'b1;
                    sys_rx_q <= 1'b1;
                    if (tx_valid_i && tx_rdy_q) begin
                        tx_shift_q <= tx_data_i;
`ifdef UART_HOST_PARITY_EN
                        tx_par_q   <= ^tx_data_i;
`endif
                        tx_rdy_q   <= 1'b0;
                        sys_rx_q   <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        sys_rx_q   <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_state_q <= ST_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        tx_bit_q <= tx_bit_q + 1'b1;
                        if (tx_bit_q == 3'd7) begin
`ifdef UART_HOST_PARITY_EN
                            sys_rx_q   <= tx_par_q;
                            tx_state_q <= ST_PAR;
`else
                            sys_rx_q   <= 1'b1;
                            tx_state_q <= ST_STOP;
`endif
                        end else begin
                            sys_rx_q   <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
`ifdef UART_HOST_PARITY_EN
                ST_PAR: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        sys_rx_q   <= 1'b1;
                        tx_state_q <= ST_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        tx_rdy_q   <= 1'b1;
                        tx_state_q <= ST_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= ST_IDLE;
            endcase
        end
    end

    assign sys_rx_o   = sys_rx_q;
    assign tx_ready_o = tx_rdy_q;

    // Receiver: sync flops preset high so reset never looks like a start edge.
    state_t          rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic            sync1_q, sync2_q, prev_q;
    logic            rx_push_q, rx_ferr_q;
`ifdef UART_HOST_PARITY_EN
    logic            rx_par_bad_q, rx_perr_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_HOST_PARITY_EN
            rx_par_bad_q <= 1'b0;
            rx_perr_q    <= 1'b0;
`endif
        end else begin
            sync1_q   <= sys_tx_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
`ifdef UART_HOST_PARITY_EN
            rx_perr_q <= 1'b0;
`endif
            case (rx_state_q)
                ST_IDLE: begin
                    rx_cnt_q <= '0;
                    if (prev_q && !sync2_q) rx_state_q <= ST_START;
                end
                ST_START: begin
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= sync2_q ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        rx_shift_q <= {sync2_q, rx_shift_q[7:1]};
`ifdef UART_HOST_PARITY_EN
                        if (rx_bit_q == 3'd7) rx_state_q <= ST_PAR;
`else
                        if (rx_bit_q == 3'd7) rx_state_q <= ST_STOP;
`endif
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
`ifdef UART_HOST_PARITY_EN
                ST_PAR: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q     <= '0;
                        rx_par_bad_q <= (^rx_shift_q) ^ sync2_q;
                        rx_state_q   <= ST_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q <= '0;
                        if (sync2_q) begin
                            rx_push_q  <= 1'b1;
`ifdef UART_HOST_PARITY_EN
                            rx_perr_q  <= rx_par_bad_q;
`endif
                            rx_state_q <= ST_IDLE;
                        end else begin
                            rx_ferr_q  <= 1'b1;
                            rx_state_q <= ST_BREAK;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                ST_BREAK: if (sync2_q) rx_state_q <= ST_IDLE;
                default:  rx_state_q <= ST_IDLE;
            endcase
        end
    end

    assign frame_err_o = rx_ferr_q;
`ifdef UART_HOST_PARITY_EN
    assign parity_err_o = rx_perr_q;
`endif

    logic [7:0]    mem_q [RX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q;
    logic          fifo_full, fifo_pop, fifo_wr;

    assign fifo_full = (count_q == (AW + 1)'(RX_FIFO_DEPTH));
    assign fifo_pop  = rx_ready_i && (count_q != '0);
    assign fifo_wr   = rx_push_q && (!fifo_full || fifo_pop);

    always_comb begin
        count_d = count_q;
        case ({fifo_wr, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            overrun_q <= rx_push_q && fifo_full && !fifo_pop;
            if (fifo_wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= rx_shift_q;
    end

    assign rx_data_o    = mem_q[rd_ptr_q];
    assign rx_valid_o   = (count_q != '0);
    assign rx_overrun_o = overrun_q;
endmodule

// File: tb/tb_uart_host_bfm.sv
// tb/tb_uart_host_bfm.sv - scoreboard bench for uart_host_bfm.
module tb_uart_host_bfm;
    localparam int OS = 16;
`ifdef UART_HOST_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b1;
    logic       loop = 1'b0;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sys_tx, sys_rx, tx_ready, rx_valid, rx_overrun, frame_err;
    logic [7:0] rx_data;
`ifdef UART_HOST_PARITY_EN
    logic       parity_err;
`endif

    assign sys_tx = loop ? sys_rx : line;

    uart_host_bfm #(.OVERSAMPLE(OS), .RX_FIFO_DEPTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .sys_tx_i(sys_tx), .sys_rx_o(sys_rx),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .rx_overrun_o(rx_overrun),
`ifdef UART_HOST_PARITY_EN
        .parity_err_o(parity_err),
`endif
        .frame_err_o(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) ferr_cnt++;
            if (rx_overrun) ovr_cnt++;
`ifdef UART_HOST_PARITY_EN
            if (parity_err) perr_cnt++;
`endif
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else begin
                    chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [7:0] b, input logic par, input logic stop);
        step(1);
        line = 1'b0;
        step(OS);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            step(OS);
        end
`ifdef UART_HOST_PARITY_EN
        line = par;
        step(OS);
`endif
        line = stop;
        step(OS);
        line = 1'b1;
        step(2);
    endtask

    task automatic send(input logic [7:0] b, output int hs_cyc);
        int n;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_ready) break;
            n++;
            if (n > 1000) begin
                chk("tx_ready_timeout", 0, 1);
                break;
            end
        end
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic check_tx(input logic [7:0] b);
        logic [NB-1:0] bits;
        logic          rdy_last;
        int            errs;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
`ifdef UART_HOST_PARITY_EN
        bits[9] = ^b;
`endif
        rdy_last = 1'b1;
        for (int bi = 0; bi < NB; bi++) begin
            errs = 0;
            for (int c = 0; c < OS; c++) begin
                @(negedge clk);
                if (sys_rx !== bits[bi]) errs++;
                if (bi == NB - 1 && c == OS - 1) rdy_last = tx_ready;
            end
            chk($sformatf("tx_bit%0d", bi), errs, 0);
        end
        chk("tx_ready_during_stop", {31'd0, rdy_last}, 0);
        @(negedge clk);
        chk("tx_ready_after_frame", {31'd0, tx_ready}, 1);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_left", exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, h1, h2, base;
        repeat (3) @(negedge clk);
        chk("rst_sys_rx", {31'd0, sys_rx}, 1);
        chk("rst_tx_ready", {31'd0, tx_ready}, 0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 0);
        chk("rst_overrun", {31'd0, rx_overrun}, 0);
        chk("rst_frame_err", {31'd0, frame_err}, 0);
        step(1);
        rst = 1'b0;
        step(3);
        @(negedge clk);
        chk("tx_ready_idle", {31'd0, tx_ready}, 1);

        send(8'hA5, h0);
        check_tx(8'hA5);
        step(5);

        loop = 1'b1;
        rx_ready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send(8'h00, h0);
        send(8'hFF, h1);
        send(8'h55, h2);
        chk("b2b_spacing_1", h1 - h0, NB * OS + 1);
        chk("b2b_spacing_2", h2 - h1, NB * OS + 1);
        drain(2000);
        step(20);
        loop = 1'b0;
        chk("loop_no_frame_err", ferr_cnt, 0);

        step(1);
        line = 1'b0;
        step(4);
        line = 1'b1;
        step(200);
        chk("glitch_rx_valid", {31'd0, rx_valid}, 0);

        inject(8'h3C, ^8'h3C, 1'b0);
        step(20);
        chk("break_frame_err", ferr_cnt, 1);
        chk("break_rx_valid", {31'd0, rx_valid}, 0);
        exp_q.push_back(8'h12);
        inject(8'h12, ^8'h12, 1'b1);
        drain(400);

        rx_ready = 1'b0;
        base = ovr_cnt;
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) exp_q.push_back(8'(i));
            inject(8'(i), ^(8'(i)), 1'b1);
        end
        step(20);
        chk("overrun_pulses", ovr_cnt - base, 1);
        chk("full_rx_valid", {31'd0, rx_valid}, 1);
        rx_ready = 1'b1;
        drain(200);
        step(5);
        chk("empty_after_drain", {31'd0, rx_valid}, 0);

`ifdef UART_HOST_PARITY_EN
        base = perr_cnt;
        exp_q.push_back(8'h07);
        inject(8'h07, 1'b0, 1'b1);
        drain(400);
        step(5);
        chk("parity_err_pulses", perr_cnt - base, 1);
        send(8'h03, h0);
        check_tx(8'h03);
`endif

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
